fp16_mul_pipe: RTL

//  Pipelined IEEE-754 binary16 multiplier; sits directly downstream of the operand-pairing stage.

---
 rtl/fp16_pkg.sv | 33 +++
 rtl/fp16_round_rne.sv | 38 +++
 rtl/fp16_mul_pipe.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 field widths, constants, operand class and field layout
// for the fp16 multiplier.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    localparam logic [15:0] PINF    = 16'h7C00;
    localparam logic [15:0] MAX_FIN = 16'h7BFF;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

    // Subnormals classify as zero, so the multiplier treats them as zero inputs.
    function automatic fp_class_e fp16_classify(input fp16_t x);
        fp_class_e c;
        if (x.exp == '0)
            c = FP_ZERO;
        else if (x.exp == '1)
            c = (x.man == '0) ? FP_INF : FP_NAN;
        else
            c = FP_NORM;
        return c;
    endfunction

endpackage

// File: rtl/fp16_round_rne.sv
// Normalises the 22-bit significand product to 10 fraction bits with
// round-to-nearest-even, adjusting the signed exponent for both carries.
module fp16_round_rne
    import fp16_pkg::*;
(
    input  logic [21:0]        mant_i,
    input  logic signed [6:0]  exp_i,
    output logic [MAN_W-1:0]   frac_o,
    output logic signed [6:0]  exp_o
);

    logic [MAN_W-1:0]  frac;
    logic              guard;
    logic              sticky;
    logic              rnd_up;
    logic signed [6:0] exp_n;
    logic [MAN_W:0]    frac_inc;

    always_comb begin
        if (mant_i[21]) begin
            frac   = mant_i[20:11];
            guard  = mant_i[10];
            sticky = |mant_i[9:0];
            exp_n  = exp_i + 7'sd1;
        end else begin
            frac   = mant_i[19:10];
            guard  = mant_i[9];
            sticky = |mant_i[8:0];
            exp_n  = exp_i;
        end
        rnd_up   = guard & (sticky | frac[0]);
        frac_inc = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
        // A carry out of the fraction leaves it all-zero and bumps the exponent.
        frac_o   = frac_inc[MAN_W-1:0];
        exp_o    = frac_inc[MAN_W] ? exp_n + 7'sd1 : exp_n;
    end

endmodule

// File: rtl/fp16_mul_pipe.sv
// Pipelined binary16 multiplier: input register, unpack, normalise/round,
// pack with special-case override. FTZ/DAZ, RNE, one pair per clock.
module fp16_mul_pipe
    import fp16_pkg::*;
#(
    parameter logic [15:0] QNAN       = 16'h7E00,
    parameter bit          SAT_ON_OVF = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        in_valid,
    output logic [15:0] result,
    output logic        out_valid,
    output logic        ovf,
    output logic        unf,
    output logic        invalid
);

    localparam int STAGES = 3;

    logic [STAGES:0] vld_pipe_q;

    fp16_t a_q, b_q;

    fp_class_e         ca_s1_q, cb_s1_q, ca_s1_d, cb_s1_d;
    logic              sign_s1_q, sign_s1_d;
    logic signed [6:0] exp_s1_q, exp_s1_d;
    logic [21:0]       mant_s1_q, mant_s1_d;

    fp_class_e         ca_s2_q, cb_s2_q;
    logic              sign_s2_q;
    logic signed [6:0] exp_s2_q, exp_rnd;
    logic [MAN_W-1:0]  frac_s2_q, frac_rnd;

    logic [15:0] result_q, result_d;
    logic        ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

    always_comb begin
        ca_s1_d   = fp16_classify(a_q);
        cb_s1_d   = fp16_classify(b_q);
        sign_s1_d = a_q.sign ^ b_q.sign;
        exp_s1_d  = $signed({2'b00, a_q.exp}) + $signed({2'b00, b_q.exp}) - 7'(BIAS);
        mant_s1_d = {11'd0, 1'b1, a_q.man} * {11'd0, 1'b1, b_q.man};
    end

    fp16_round_rne u_round (
        .mant_i (mant_s1_q),
        .exp_i  (exp_s1_q),
        .frac_o (frac_rnd),
        .exp_o  (exp_rnd)
    );

    // Special operands win over the arithmetic path; range checks use the rounded exponent.
    always_comb begin
        result_d = {sign_s2_q, exp_s2_q[EXP_W-1:0], frac_s2_q};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inv_d    = 1'b0;
        if (ca_s2_q == FP_NAN || cb_s2_q == FP_NAN ||
            (ca_s2_q == FP_INF && cb_s2_q == FP_ZERO) ||
            (ca_s2_q == FP_ZERO && cb_s2_q == FP_INF)) begin
            result_d = QNAN;
            inv_d    = 1'b1;
        end else if (ca_s2_q == FP_INF || cb_s2_q == FP_INF) begin
            result_d = {sign_s2_q, PINF[14:0]};
        end else if (ca_s2_q == FP_ZERO || cb_s2_q == FP_ZERO) begin
            result_d = {sign_s2_q, 15'h0};
        end else if (exp_s2_q >= 7'(EXP_MAX)) begin
            ovf_d    = 1'b1;
            result_d = SAT_ON_OVF ? {sign_s2_q, MAX_FIN[14:0]} : {sign_s2_q, PINF[14:0]};
        end else if (exp_s2_q <= 7'sd0) begin
            unf_d    = 1'b1;
            result_d = {sign_s2_q, 15'h0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ca_s1_q    <= FP_ZERO;
            cb_s1_q    <= FP_ZERO;
            sign_s1_q  <= 1'b0;
            exp_s1_q   <= '0;
            mant_s1_q  <= '0;
            ca_s2_q    <= FP_ZERO;
            cb_s2_q    <= FP_ZERO;
            sign_s2_q  <= 1'b0;
            exp_s2_q   <= '0;
            frac_s2_q  <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], in_valid};
            if (in_valid) begin
                a_q <= op_a;
                b_q <= op_b;
            end
            if (vld_pipe_q[0]) begin
                ca_s1_q   <= ca_s1_d;
                cb_s1_q   <= cb_s1_d;
                sign_s1_q <= sign_s1_d;
                exp_s1_q  <= exp_s1_d;
                mant_s1_q <= mant_s1_d;
            end
            if (vld_pipe_q[1]) begin
                ca_s2_q   <= ca_s1_q;
                cb_s2_q   <= cb_s1_q;
                sign_s2_q <= sign_s1_q;
                exp_s2_q  <= exp_rnd;
                frac_s2_q <= frac_rnd;
            end
            // Outputs only move on a valid result, so they hold across bubbles.
            if (vld_pipe_q[2]) begin
                result_q <= result_d;
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
                inv_q    <= inv_d;
            end
        end
    end

    assign out_valid = vld_pipe_q[STAGES];
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign invalid   = inv_q;

endmodule
